// File: rtl/ahb_master_if_pkg.sv
// ahb_master_if_pkg: AHB widths, bus encodings and master FSM states shared by the AHB master slice
package ahb_master_if_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;
    typedef enum logic [2:0] {
        HB_SINGLE = 3'b000,
        HB_INCR   = 3'b001,
        HB_INCR4  = 3'b011,
        HB_INCR8  = 3'b101,
        HB_INCR16 = 3'b111
    } hburst_e;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_LAST, ST_ERR2} mst_state_e;
    // Fixed-length bursts are only legal when the whole burst stays inside one 1KB page
    function automatic hburst_e burst_sel(input int len, input logic [9:0] a10, input logic [2:0] size);
        logic w_cross;
        w_cross = (int'(a10) + (len << size)) > 1024;
        return (len == 1) ? HB_SINGLE :
               w_cross    ? HB_INCR   :
               (len == 4) ? HB_INCR4  :
               (len == 8) ? HB_INCR8  :
               (len == 16) ? HB_INCR16 : HB_INCR;
    endfunction
endpackage

// File: rtl/ahb_master_if_if.sv
// ahb_master_if_if: AHB address/control/data bus between one master and the interconnect
interface ahb_master_if_if;
    import ahb_master_if_pkg::*;
    logic [ADDR_WIDTH-1:0]   Haddr;
    logic [1:0]              Htrans;
    logic                    Hwrite;
    logic [2:0]              Hsize;
    logic [2:0]              Hburst;
    logic [DATA_WIDTH-1:0]   HWdata;
    logic [DATA_WIDTH/8-1:0] Hstrob;
    logic                    Hready;
    logic [DATA_WIDTH-1:0]   HRdata;
    logic [1:0]              Hresp;
    modport master (
        output Haddr, Htrans, Hwrite, Hsize, Hburst, HWdata, Hstrob,
        input  Hready, HRdata, Hresp
    );
    modport slave (
        input  Haddr, Htrans, Hwrite, Hsize, Hburst, HWdata, Hstrob,
        output Hready, HRdata, Hresp
    );
endinterface

// File: rtl/ahb_master_if_strobe_gen.sv
// ahb_strobe_gen: byte-lane enables for a 32-bit AHB beat from transfer size and low address bits
module ahb_strobe_gen (
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_strob
);
    always_comb
        o_strob = (i_size == 3'd0) ? (4'b0001 << i_addr_lo) :
                  (i_size == 3'd1) ? (i_addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/ahb_master_if.sv
// ahb_master_if: single-request AHB initiator with pipelined address/data phases,
// SINGLE/INCRx/INCR bursts, 1KB page splitting, wait states and two-cycle ERROR handling
module ahb_master_if
    import ahb_master_if_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic                  Hclk,
    input  logic                  Hreset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_write,
    input  logic [2:0]            req_size,
    input  logic [LEN_W-1:0]      req_len,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  done,
    output logic                  err,
    ahb_master_if_if.master       bus
);
    mst_state_e            r_state;
    htrans_e               r_trans;
    hburst_e               r_burst;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LEN_W-1:0]      r_left;
    logic                  r_dpend;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdata_valid;
    logic                  r_done;
    logic                  r_err;
    logic [LEN_W-1:0]      w_len;
    logic                  w_adone;
    logic                  w_dend;
    logic                  w_derr1;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [3:0]            w_strob;
    always_comb begin
        w_len       = (req_len == '0) ? LEN_W'(1) : req_len;
        w_adone     = bus.Hready && (r_trans != HT_IDLE);
        w_dend      = bus.Hready && r_dpend;
        w_derr1     = r_dpend && !bus.Hready && (bus.Hresp == HRESP_ERROR);
        w_next_addr = r_addr + (ADDR_WIDTH'(1) << r_size);
    end
    ahb_strobe_gen u_strobe (
        .i_size    (r_size),
        .i_addr_lo (r_addr[1:0]),
        .o_strob   (w_strob)
    );
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state       <= ST_IDLE;
            r_trans       <= HT_IDLE;
            r_burst       <= HB_SINGLE;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_size        <= '0;
            r_wdata       <= '0;
            r_left        <= '0;
            r_dpend       <= 1'b0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_rdata_valid <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            if (w_adone && r_write)
                r_wdata <= wdata;
            if (w_dend && !r_write && bus.Hresp == HRESP_OKAY) begin
                r_rdata       <= bus.HRdata;
                r_rdata_valid <= 1'b1;
            end
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    if (req_size > 3'd2) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end else begin
                        r_state <= ST_ADDR;
                        r_trans <= HT_NONSEQ;
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_size  <= req_size;
                        r_burst <= burst_sel(int'(w_len), req_addr[9:0], req_size);
                        r_left  <= w_len - LEN_W'(1);
                    end
                end
                ST_ADDR: if (w_derr1) begin
                    r_trans <= HT_IDLE;
                    r_dpend <= 1'b0;
                    r_state <= ST_ERR2;
                end else if (w_adone) begin
                    r_dpend <= 1'b1;
                    if (r_left != '0) begin
                        r_addr  <= w_next_addr;
                        // A beat that starts a new 1KB page must restart the burst
                        r_trans <= (w_next_addr[9:0] == 10'd0) ? HT_NONSEQ : HT_SEQ;
                        r_left  <= r_left - LEN_W'(1);
                    end else begin
                        r_trans <= HT_IDLE;
                        r_state <= ST_LAST;
                    end
                end
                ST_LAST: if (w_derr1) begin
                    r_dpend <= 1'b0;
                    r_state <= ST_ERR2;
                end else if (w_dend) begin
                    r_dpend <= 1'b0;
                    r_done  <= 1'b1;
                    r_err   <= (bus.Hresp == HRESP_ERROR);
                    r_state <= ST_IDLE;
                end
                ST_ERR2: if (bus.Hready) begin
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign req_ready   = (r_state == ST_IDLE);
    assign wdata_ready = w_adone && r_write;
    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;
    assign done        = r_done;
    assign err         = r_err;
    assign bus.Haddr   = r_addr;
    assign bus.Htrans  = r_trans;
    assign bus.Hwrite  = r_write;
    assign bus.Hsize   = r_size;
    assign bus.Hburst  = r_burst;
    assign bus.HWdata  = r_wdata;
    assign bus.Hstrob  = (r_trans != HT_IDLE) ? w_strob : '0;
endmodule
